lsu_mem_adapter: RTL and testbench
==================================

Name: lsu_mem_adapter

Overview:
Load/store adapter between the core's byte-addressed memory request port and the 64-bit word-addressed data memory (wmask byte-lane write, combinational read). It accepts one request at a time via valid/ready, converts byte address and access size into a word address, byte write mask and lane-aligned write data, and returns sign- or zero-extended load data. Accesses that cross a 64-bit word boundary are either split into two memory cycles or rejected, depending on the build option.

Parameters:
ADDR_WID, 9, memory word-address width; must match the data memory.
DATA_DEP, 512, memory depth in words; used only for bench and assertion checks. Word addresses wrap modulo 2^ADDR_WID.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  adapter can accept a request
req_addr  input  ADDR_WID+3  byte address; [2:0] is the byte offset, the upper bits are the word address
req_we  input  1  1 = store, 0 = load
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = double (n = 1 << size bytes)
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
req_wdata  input  64  store data, low n bytes used
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  64  extended load data; 0 for stores and errors
rsp_err  output  1  access rejected; qualified by rsp_valid
mem_addr  output  ADDR_WID  to memory addr
mem_rdata  input  64  from memory rdata, combinational
mem_wr_en  output  1  to memory wr_en
mem_wdata  output  64  to memory wdata
mem_wmask  output  8  to memory wmask

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- While rst=1 and on the cycle after: rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=0 during rst, state=IDLE. mem_wr_en is forced to 0 combinationally whenever rst=1.
- FSM states: IDLE, ACC1, ACC2, RESP.
- Request capture:
  - req_ready=1 only in IDLE.
  - On a cycle with req_valid & req_ready, register addr, we, size, unsigned and wdata, then go to ACC1.
  - Let off = addr[2:0] and n = 1 << size. The access is crossing if off + n > 8.
- ACC1:
  - mem_addr = word address W.
  - Lane mask m = ((1<<n)-1) << off, computed 16 bits wide.
  - mem_wmask = m[7:0] when storing, else 0. mem_wr_en = we.
  - mem_wdata = (wdata << 8*off)[63:0].
  - Capture mem_rdata into a 128-bit holding register, low half.
  - Next state is ACC2 if crossing, else RESP.
- ACC2 (crossing only):
  - mem_addr = W+1 modulo 2^ADDR_WID, so word 2^ADDR_WID-1 wraps to word 0.
  - mem_wmask = m[15:8] when storing.
  - mem_wdata = (wdata << 8*off)[127:64].
  - Capture mem_rdata into the high half of the holding register. Next state is RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - For loads, rsp_rdata = (hold >> 8*off), low n bytes, sign- or zero-extended from bit 8n-1.
  - For stores, rsp_rdata = 0.
- Outside ACC1/ACC2: mem_wr_en=0, mem_wmask=0, mem_wdata=0, mem_addr=0.
- Latency from acceptance edge to rsp_valid: 2 cycles when not crossing, 3 cycles when crossing. Throughput is one request per 3 (or 4) cycles.
- Misalignment that stays within a word (e.g. half at off=3) is a single access and is not an error.
- No response back-pressure: rsp_valid is a pulse the consumer must take.
- rst mid-operation: abandon the access and return to IDLE. No memory write occurs in or after the reset cycle. A completed ACC1 write of a split store is not rolled back.
- req_valid while not ready: ignored. The requester holds it.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined: crossing accesses are split through ACC2 as above.
- Undefined: a crossing request goes IDLE -> RESP directly with no memory cycle (mem_wr_en stays 0). The response is rsp_valid=1, rsp_err=1, rsp_rdata=0. ACC2 logic and the upper half of the holding register are not built.

Test Plan:
- Aligned byte store: addr 0x013 (word 2, off 3), size 0, wdata 0xA5 -> one mem cycle with mem_addr=2, mem_wmask=0x08, mem_wdata=0xA5000000, mem_wr_en=1. Response 2 cycles after accept, rsp_rdata=0.
- Signed half load: word 4 preset to 0x0000_0000_8001_0000, addr 0x022, size 1, unsigned 0 -> rsp_rdata=0xFFFF_FFFF_FFFF_8001. Same request with unsigned 1 -> 0x0000_0000_0000_8001.
- Split word store (macro on): addr 0x00E, size 2, wdata 0x11223344 -> word 1 gets mask 0xC0 with bytes 44,33 at [63:48]; word 2 gets mask 0x03 with bytes 22,11 at [15:0]. rsp_valid arrives 3 cycles after accept, rsp_err=0.
- Wrap and reject: ADDR_WID=9, double load at addr 0xFFC:
  - Macro on: words 511 then 0 are read, and the data is combined correctly.
  - Macro off: rsp_err=1, rsp_rdata=0, no mem_wr_en activity.
- Reset mid-split: assert rst in the ACC2 cycle of a split store -> word W+1 is unchanged, no rsp_valid, req_ready=1 the cycle after rst drops.
- Back-to-back: req_valid held high with 3 different requests -> req_ready low in ACC/RESP states, each request accepted once, responses in order, no request dropped or duplicated.

Source files
------------

// File: rtl/lsu_mem_adapter_if.sv
// Request/response and data-memory bus bundle for lsu_mem_adapter.
// The adapter takes the slave view; the core/memory side takes the master view.
interface lsu_mem_adapter_if #(
    parameter int ADDR_WID = 9
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WID+2:0]   req_addr;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [63:0]           req_wdata;
    logic                  rsp_valid;
    logic [63:0]           rsp_rdata;
    logic                  rsp_err;
    logic [ADDR_WID-1:0]   mem_addr;
    logic [63:0]           mem_rdata;
    logic                  mem_wr_en;
    logic [63:0]           mem_wdata;
    logic [7:0]            mem_wmask;

    modport master (
        output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr, mem_wr_en, mem_wdata, mem_wmask,
        output mem_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_addr, mem_wr_en, mem_wdata, mem_wmask,
        input  mem_rdata
    );
endinterface

// File: rtl/lsu_mem_adapter.sv
// Byte-addressed load/store adapter onto a 64-bit word memory with lane masks.
// Build option LSU_MISALIGN_SPLIT_EN: split word-crossing accesses in two cycles instead of rejecting them.
module lsu_mem_adapter #(
    parameter int ADDR_WID = 9,
    parameter int DATA_DEP = 512
) (
    input  logic             clk,
    input  logic             rst,
    lsu_mem_adapter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC1 = 2'd1,
        ST_ACC2 = 2'd2,
        ST_RESP = 2'd3
    } state_t;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam int SPAN_W = 128;
    localparam int MASK_W = 16;
`else
    localparam int SPAN_W = 64;
    localparam int MASK_W = 8;
`endif

    if (DATA_DEP > (1 << ADDR_WID)) begin : g_dep_check
        $error("lsu_mem_adapter: DATA_DEP exceeds the word-address range");
    end

    state_t              state_r;
    state_t              state_next_s;
    logic [ADDR_WID+2:0] addr_r;
    logic                we_r;
    logic [1:0]          size_r;
    logic                uns_r;
    logic [63:0]         wdata_r;
    logic                cross_r;
    logic [SPAN_W-1:0]   hold_r;
    logic                req_cross_s;
    logic [ADDR_WID-1:0] word_s;
    logic [MASK_W-1:0]   lane_mask_s;
    logic [SPAN_W-1:0]   wdata_sh_s;

    // True when an access of 2^size bytes starting at byte offset off runs past byte 7.
    function automatic logic crosses_word(input logic [2:0] off, input logic [1:0] size);
        logic [3:0] last_s;
        last_s = {1'b0, off} + (4'd1 << size);
        return (last_s > 4'd8);
    endfunction

    function automatic logic [7:0] lane_base(input logic [1:0] size);
        case (size)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            2'd3:    return 8'hFF;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [63:0] load_extend(input logic [63:0] raw, input logic [1:0] size,
                                                input logic uns);
        case (size)
            2'd0:    return uns ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            2'd1:    return uns ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            2'd2:    return uns ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            2'd3:    return raw;
            default: return raw;
        endcase
    endfunction

    assign req_cross_s = crosses_word(bus.req_addr[2:0], bus.req_size);
    assign word_s      = addr_r[ADDR_WID+2:3];
    assign lane_mask_s = MASK_W'(lane_base(size_r)) << addr_r[2:0];
    assign wdata_sh_s  = SPAN_W'(wdata_r) << {addr_r[2:0], 3'b000};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    state_next_s = ST_ACC1;
`else
                    // A crossing request is answered with an error and never touches memory.
                    state_next_s = req_cross_s ? ST_RESP : ST_ACC1;
`endif
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACC1: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                state_next_s = cross_r ? ST_ACC2 : ST_RESP;
`else
                state_next_s = ST_RESP;
`endif
            end
            ST_ACC2: state_next_s = ST_RESP;
            ST_RESP: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Request capture and read-data holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r  <= '0;
            we_r    <= 1'b0;
            size_r  <= 2'd0;
            uns_r   <= 1'b0;
            wdata_r <= 64'd0;
            cross_r <= 1'b0;
            hold_r  <= '0;
        end else begin
            if ((state_r == ST_IDLE) && bus.req_valid) begin
                addr_r  <= bus.req_addr;
                we_r    <= bus.req_we;
                size_r  <= bus.req_size;
                uns_r   <= bus.req_unsigned;
                wdata_r <= bus.req_wdata;
                cross_r <= req_cross_s;
            end
            if (state_r == ST_ACC1) begin
                hold_r[63:0] <= bus.mem_rdata;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            if (state_r == ST_ACC2) begin
                hold_r[127:64] <= bus.mem_rdata;
            end
`endif
        end
    end

    // Memory-side and response outputs decoded from the current state.
    always_comb begin
        bus.req_ready = (state_r == ST_IDLE) && !rst;
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = 1'b0;
        bus.rsp_rdata = 64'd0;
        bus.mem_addr  = '0;
        bus.mem_wr_en = 1'b0;
        bus.mem_wmask = 8'h00;
        bus.mem_wdata = 64'd0;
        case (state_r)
            ST_ACC1: begin
                bus.mem_addr  = word_s;
                bus.mem_wr_en = we_r && !rst;
                bus.mem_wmask = we_r ? lane_mask_s[7:0] : 8'h00;
                bus.mem_wdata = wdata_sh_s[63:0];
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ST_ACC2: begin
                bus.mem_addr  = word_s + {{(ADDR_WID-1){1'b0}}, 1'b1};
                bus.mem_wr_en = we_r && !rst;
                bus.mem_wmask = we_r ? lane_mask_s[15:8] : 8'h00;
                bus.mem_wdata = wdata_sh_s[127:64];
            end
`endif
            ST_RESP: begin
                bus.rsp_valid = !rst;
`ifdef LSU_MISALIGN_SPLIT_EN
                bus.rsp_err   = 1'b0;
                if (!rst && !we_r) begin
`else
                bus.rsp_err   = cross_r && !rst;
                if (!rst && !we_r && !cross_r) begin
`endif
                    bus.rsp_rdata = load_extend(64'(hold_r >> {addr_r[2:0], 3'b000}), size_r, uns_r);
                end else begin
                    bus.rsp_rdata = 64'd0;
                end
            end
            default: begin
                bus.rsp_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Directed self-checking bench for lsu_mem_adapter with a behavioural lane-masked word memory.
// Expectations follow whichever LSU_MISALIGN_SPLIT_EN build is compiled.
module tb_lsu_mem_adapter;

    localparam int ADDR_WID = 9;

    logic clk;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   wr_cnt   = 0;

    logic [63:0] mem [0:511];
    logic        pre_en;
    logic [8:0]  pre_addr;
    logic [63:0] pre_data;

    logic [8:0]  acc1_addr;
    logic [7:0]  acc1_mask;
    logic [63:0] acc1_wdata;
    logic        acc1_we;

    lsu_mem_adapter_if #(.ADDR_WID(ADDR_WID)) ifc ();

    lsu_mem_adapter #(.ADDR_WID(ADDR_WID), .DATA_DEP(512)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    assign ifc.mem_rdata = mem[ifc.mem_addr];

    // Memory model: bench presets take priority over adapter writes.
    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (ifc.mem_wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (ifc.mem_wmask[b]) mem[ifc.mem_addr][8*b +: 8] <= ifc.mem_wdata[8*b +: 8];
            end
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preset(input logic [8:0] a, input logic [63:0] d);
        pre_addr = a;
        pre_data = d;
        pre_en   = 1'b1;
        tick();
        pre_en   = 1'b0;
    endtask

    task automatic drive_req(input logic [11:0] addr, input logic we, input logic [1:0] size,
                             input logic uns, input logic [63:0] wdata);
        ifc.req_addr     = addr;
        ifc.req_we       = we;
        ifc.req_size     = size;
        ifc.req_unsigned = uns;
        ifc.req_wdata    = wdata;
    endtask

    // One complete transaction: accept, snapshot the first access cycle, wait (bounded) for the response.
    task automatic do_req(input string tag, input logic [11:0] addr, input logic we,
                          input logic [1:0] size, input logic uns, input logic [63:0] wdata,
                          input int exp_lat, input logic [63:0] exp_rdata, input logic exp_err);
        int lat;
        drive_req(addr, we, size, uns, wdata);
        ifc.req_valid = 1'b1;
        check_eq({tag, "_ready"}, 64'(ifc.req_ready), 64'd1);
        tick();
        ifc.req_valid = 1'b0;
        acc1_addr  = ifc.mem_addr;
        acc1_mask  = ifc.mem_wmask;
        acc1_wdata = ifc.mem_wdata;
        acc1_we    = ifc.mem_wr_en;
        lat = 1;
        while (!ifc.rsp_valid && lat < 8) begin
            tick();
            lat++;
        end
        check_eq({tag, "_lat"},   64'(lat), 64'(exp_lat));
        check_eq({tag, "_err"},   64'(ifc.rsp_err), 64'(exp_err));
        check_eq({tag, "_rdata"}, ifc.rsp_rdata, exp_rdata);
        tick();
    endtask

    logic [63:0] b2b_exp [0:2];
    logic [11:0] b2b_addr [0:2];

    initial begin
        int acc_n;
        int rsp_n;
        int acc_cyc [0:2];
        int wr_before;
        logic fire;

        clk = 1'b0;
        rst = 1'b1;
        pre_en = 1'b0;
        pre_addr = 9'd0;
        pre_data = 64'd0;
        ifc.req_valid = 1'b0;
        drive_req(12'h000, 1'b0, 2'd0, 1'b0, 64'd0);

        // Reset: a store presented under reset must be ignored.
        repeat (2) tick();
        drive_req(12'h013, 1'b1, 2'd0, 1'b0, 64'hA5);
        ifc.req_valid = 1'b1;
        #1;
        check_eq("rst_rsp_valid", 64'(ifc.rsp_valid), 64'd0);
        check_eq("rst_rsp_err",   64'(ifc.rsp_err),   64'd0);
        check_eq("rst_rsp_rdata", ifc.rsp_rdata,      64'd0);
        check_eq("rst_req_ready", 64'(ifc.req_ready), 64'd0);
        check_eq("rst_wr_en",     64'(ifc.mem_wr_en), 64'd0);
        tick();
        rst = 1'b0;
        ifc.req_valid = 1'b0;
        #1;
        check_eq("rst_wr_cnt",     64'(wr_cnt),        64'd0);
        check_eq("post_rst_ready", 64'(ifc.req_ready), 64'd1);
        tick();
        check_eq("post_rst_valid", 64'(ifc.rsp_valid), 64'd0);

        // Aligned byte store to word 2, offset 3.
        preset(9'd2, 64'h1111_2222_3333_4444);
        do_req("bst", 12'h013, 1'b1, 2'd0, 1'b0, 64'hA5, 2, 64'd0, 1'b0);
        check_eq("bst_addr",  64'(acc1_addr),  64'd2);
        check_eq("bst_mask",  64'(acc1_mask),  64'h08);
        check_eq("bst_wdata", acc1_wdata,      64'hA500_0000);
        check_eq("bst_we",    64'(acc1_we),    64'd1);
        check_eq("bst_mem",   mem[2],          64'h1111_2222_A533_4444);

        // Half loads, signed then unsigned, plus a misaligned half that stays in the word.
        preset(9'd4, 64'h0000_0000_8001_0000);
        do_req("hld_s", 12'h022, 1'b0, 2'd1, 1'b0, 64'd0, 2, 64'hFFFF_FFFF_FFFF_8001, 1'b0);
        check_eq("hld_s_mask", 64'(acc1_mask), 64'h00);
        check_eq("hld_s_we",   64'(acc1_we),   64'd0);
        do_req("hld_u", 12'h022, 1'b0, 2'd1, 1'b1, 64'd0, 2, 64'h0000_0000_0000_8001, 1'b0);
        do_req("hld_mis", 12'h023, 1'b0, 2'd1, 1'b0, 64'd0, 2, 64'h0000_0000_0000_0080, 1'b0);

        // Double and signed word loads within word 5.
        preset(9'd5, 64'h8877_6655_4433_2211);
        do_req("dld", 12'h028, 1'b0, 2'd3, 1'b0, 64'd0, 2, 64'h8877_6655_4433_2211, 1'b0);
        do_req("wld_s", 12'h02C, 1'b0, 2'd2, 1'b0, 64'd0, 2, 64'hFFFF_FFFF_8877_6655, 1'b0);

        // Word store crossing from word 1 into word 2.
        preset(9'd1, 64'hAAAA_AAAA_AAAA_AAAA);
        preset(9'd2, 64'hBBBB_BBBB_BBBB_BBBB);
        wr_before = wr_cnt;
`ifdef LSU_MISALIGN_SPLIT_EN
        do_req("xst", 12'h00E, 1'b1, 2'd2, 1'b0, 64'h1122_3344, 3, 64'd0, 1'b0);
        check_eq("xst_mask1", 64'(acc1_mask), 64'hC0);
        check_eq("xst_mem1",  mem[1], 64'h3344_AAAA_AAAA_AAAA);
        check_eq("xst_mem2",  mem[2], 64'hBBBB_BBBB_BBBB_1122);
        check_eq("xst_wrs",   64'(wr_cnt - wr_before), 64'd2);
`else
        do_req("xst", 12'h00E, 1'b1, 2'd2, 1'b0, 64'h1122_3344, 1, 64'd0, 1'b1);
        check_eq("xst_mem1",  mem[1], 64'hAAAA_AAAA_AAAA_AAAA);
        check_eq("xst_mem2",  mem[2], 64'hBBBB_BBBB_BBBB_BBBB);
        check_eq("xst_wrs",   64'(wr_cnt - wr_before), 64'd0);
`endif

        // Double load at the top word, wrapping to word 0.
        preset(9'd511, 64'h8877_6655_4433_2211);
        preset(9'd0,   64'hFFEE_DDCC_BBAA_9988);
`ifdef LSU_MISALIGN_SPLIT_EN
        do_req("wrap", 12'hFFC, 1'b0, 2'd3, 1'b0, 64'd0, 3, 64'hBBAA_9988_8877_6655, 1'b0);
        check_eq("wrap_addr1", 64'(acc1_addr), 64'd511);
`else
        do_req("wrap", 12'hFFC, 1'b0, 2'd3, 1'b0, 64'd0, 1, 64'd0, 1'b1);
        check_eq("wrap_we", 64'(acc1_we), 64'd0);
`endif

        // Reset in the middle of a store: the aborted cycle must not write.
`ifdef LSU_MISALIGN_SPLIT_EN
        preset(9'd1, 64'hAAAA_AAAA_AAAA_AAAA);
        preset(9'd2, 64'hBBBB_BBBB_BBBB_BBBB);
        drive_req(12'h00E, 1'b1, 2'd2, 1'b0, 64'h5566_7788);
        ifc.req_valid = 1'b1;
        tick();
        ifc.req_valid = 1'b0;
        tick();
`else
        preset(9'd6, 64'h0123_4567_89AB_CDEF);
        drive_req(12'h030, 1'b1, 2'd0, 1'b0, 64'h5A);
        ifc.req_valid = 1'b1;
        tick();
        ifc.req_valid = 1'b0;
`endif
        rst = 1'b1;
        #1;
        check_eq("mrst_wr_en", 64'(ifc.mem_wr_en), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check_eq("mrst_valid0", 64'(ifc.rsp_valid), 64'd0);
        check_eq("mrst_ready0", 64'(ifc.req_ready), 64'd1);
        tick();
        check_eq("mrst_valid1", 64'(ifc.rsp_valid), 64'd0);
        check_eq("mrst_ready1", 64'(ifc.req_ready), 64'd1);
`ifdef LSU_MISALIGN_SPLIT_EN
        check_eq("mrst_mem1", mem[1], 64'h7788_AAAA_AAAA_AAAA);
        check_eq("mrst_mem2", mem[2], 64'hBBBB_BBBB_BBBB_BBBB);
`else
        check_eq("mrst_mem6", mem[6], 64'h0123_4567_89AB_CDEF);
`endif

        // Back-to-back loads with req_valid held high.
        b2b_exp[0] = 64'h1010_1010_0000_000A;
        b2b_exp[1] = 64'h2121_2121_0000_000B;
        b2b_exp[2] = 64'h3232_3232_0000_000C;
        b2b_addr[0] = 12'h050;
        b2b_addr[1] = 12'h058;
        b2b_addr[2] = 12'h060;
        preset(9'd10, b2b_exp[0]);
        preset(9'd11, b2b_exp[1]);
        preset(9'd12, b2b_exp[2]);
        acc_n = 0;
        rsp_n = 0;
        for (int i = 0; i < 3; i++) acc_cyc[i] = 0;
        drive_req(b2b_addr[0], 1'b0, 2'd3, 1'b0, 64'd0);
        ifc.req_valid = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (ifc.rsp_valid) begin
                if (rsp_n < 3) check_eq("b2b_rdata", ifc.rsp_rdata, b2b_exp[rsp_n]);
                rsp_n++;
            end
            fire = ifc.req_valid && ifc.req_ready;
            tick();
            if (fire) begin
                if (acc_n < 3) acc_cyc[acc_n] = cyc;
                acc_n++;
                if (acc_n < 3) drive_req(b2b_addr[acc_n], 1'b0, 2'd3, 1'b0, 64'd0);
                else ifc.req_valid = 1'b0;
            end
        end
        ifc.req_valid = 1'b0;
        check_eq("b2b_accepts", 64'(acc_n), 64'd3);
        check_eq("b2b_rsps",    64'(rsp_n), 64'd3);
        check_eq("b2b_gap01",   64'(acc_cyc[1] - acc_cyc[0]), 64'd3);
        check_eq("b2b_gap12",   64'(acc_cyc[2] - acc_cyc[1]), 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
